// File: rtl/pll_lock_supervisor.sv
// Purpose : PLL reset/lock supervisor. Drives the PLL reset, qualifies the asynchronous PLL locked
//           flag and releases the core reset only after lock has been stable for LOCK_CYCLES.
// Latency : locked sampled at edge k -> FSM reacts at edge k+2 (2-FF synchronizer); core_rst_n
//           rises LOCK_CYCLES edges after STABLE entry and falls on the edge that sees lock loss.
// Backpressure: none; level inputs are sampled every refclk cycle, outputs are registered levels.
//
// Ports:
//   refclk      in   1  free-running 50 MHz board clock, the only clock of this block
//   rst_n       in   1  synchronous active-low reset
//   locked      in   1  PLL locked flag, asynchronous to refclk
//   sw_reset    in   1  level core-reset request, synchronous to refclk
//   pll_rst     out  1  PLL reset, active-high, registered (high only in PLL_RST)
//   core_rst_n  out  1  core reset, active-low, registered (high only in RUN)
//   sts_state   out  3  current FSM state encoding
//   relock_cnt  out  8  saturating count of RUN->LOST events
//
// Build option: define PLL_LOCK_CNT_EN to build the relock event counter; when it is undefined
// relock_cnt is tied to zero and no counter logic exists.

module pll_lock_supervisor #(
   parameter int RST_PULSE    = 16,
   parameter int LOCK_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int CNT_W        = 16
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       locked,
   input  logic       sw_reset,
   output logic       pll_rst,
   output logic       core_rst_n,
   output logic [2:0] sts_state,
   output logic [7:0] relock_cnt
);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_LOST      = 3'd4
   } state_e;

   // Terminal counter values; each one forces a state change, so cnt never wraps.
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             pll_rst_q;
   logic             core_rst_n_q;
   logic             sync1_q;
   logic             lock_s_q;

   // ------------------------------------------------------------------
   // locked synchronizer: the FSM only ever looks at lock_s_q.
   // ------------------------------------------------------------------
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= locked;
         lock_s_q <= sync1_q;
      end
   end

   assign cnt_d = cnt_q + CNT_W'(1);

   // ------------------------------------------------------------------
   // Supervisor FSM with registered outputs; outputs change on the same
   // edge that enters the state that owns them.
   // ------------------------------------------------------------------
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q      <= ST_PLL_RST;
         cnt_q        <= '0;
         pll_rst_q    <= 1'b1;
         core_rst_n_q <= 1'b0;
      end else begin
         case (state_q)
            ST_PLL_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_q   <= ST_WAIT_LOCK;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_WAIT_LOCK: begin
               if (lock_s_q) begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == TO_LAST) begin
                  state_q   <= ST_PLL_RST;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_STABLE: begin
               if (!lock_s_q) begin
                  state_q <= ST_WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (sw_reset) begin
                  // A software request keeps the qualification window from starting.
                  cnt_q <= '0;
               end else if (cnt_q == LOCK_LAST) begin
                  state_q      <= ST_RUN;
                  cnt_q        <= '0;
                  core_rst_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_RUN: begin
               // Lock loss wins over a simultaneous software reset request.
               if (!lock_s_q) begin
                  state_q      <= ST_LOST;
                  cnt_q        <= '0;
                  core_rst_n_q <= 1'b0;
               end else if (sw_reset) begin
                  state_q      <= ST_STABLE;
                  cnt_q        <= '0;
                  core_rst_n_q <= 1'b0;
               end
            end

            ST_LOST: begin
               if (lock_s_q) begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == TO_LAST) begin
                  state_q   <= ST_PLL_RST;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            default: begin
               state_q      <= ST_PLL_RST;
               cnt_q        <= '0;
               pll_rst_q    <= 1'b1;
               core_rst_n_q <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst    = pll_rst_q;
   assign core_rst_n = core_rst_n_q;
   assign sts_state  = state_q;

   // ------------------------------------------------------------------
   // Relock event counter (optional).
   // ------------------------------------------------------------------
`ifdef PLL_LOCK_CNT_EN
   logic [7:0] relock_q;
   logic [7:0] relock_d;

   // Counts the exact condition that moves RUN to LOST; sticks at 255.
   always_comb begin
      relock_d = relock_q;
      if (state_q == ST_RUN && !lock_s_q && relock_q != 8'hFF) begin
         relock_d = relock_q + 8'd1;
      end
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         relock_q <= 8'h00;
      end else begin
         relock_q <= relock_d;
      end
   end

   assign relock_cnt = relock_q;
`else
   assign relock_cnt = 8'h00;
`endif

endmodule
